// File: rtl/div8_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div8_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    // Iteration counter width: must hold the value WIDTH.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_scs8.sv
// Combinational subtract-compare-select stage: one restoring-division step.
module div_scs8
    import div8_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rin,
    input  logic [WIDTH-1:0] din,
    output logic             q,
    output logic [WIDTH-1:0] rout,
    output logic [WIDTH-1:0] diff
);

    always_comb begin
        diff = rin - din;
        q    = (rin >= din);
        rout = q ? diff : rin;
    end

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider: one SCS iteration per clock, MSB first,
// with a registered done pulse and divide-by-zero reporting.
module div8_seq
    import div8_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             drv_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_w(WIDTH);

    div_state_t state, state_nx;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial;
    logic             scs_q;
    logic [WIDTH-1:0] scs_rout;
    logic [WIDTH-1:0] scs_diff;
    logic             q_bit;
    logic [WIDTH-1:0] r_next;
    logic             last_iter;

    assign trial = {r_q, q_q[WIDTH-1]};

    div_scs8 #(.WIDTH(WIDTH)) u_scs (
        .rin  (trial[WIDTH-1:0]),
        .din  (d_q),
        .q    (scs_q),
        .rout (scs_rout),
        .diff (scs_diff)
    );

    // A set carry-out bit means the trial value exceeds any WIDTH-bit divisor,
    // so the truncated difference is the exact new remainder.
    always_comb begin
        q_bit     = trial[WIDTH] | scs_q;
        r_next    = trial[WIDTH] ? scs_diff : scs_rout;
        last_iter = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge drv_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (divisor == '0) ? DONE : RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge drv_clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_q         <= dividend;
                        d_q         <= divisor;
                        r_q         <= '0;
                        count       <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    r_q   <= r_next;
                    q_q   <= {q_q[WIDTH-2:0], q_bit};
                    count <= count + CW'(1);
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b1;
                    // Divide-by-zero never iterates, so q_q still holds the dividend.
                    if (d_q == '0) begin
                        quotient    <= '1;
                        remainder   <= q_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= q_q;
                        remainder <= r_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: arithmetic reference model with
// per-cycle comparison, directed literal cases, then randomized traffic.
module tb_div8_seq;

    localparam int unsigned W = 8;

    logic         drv_clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int unsigned total = 0;
    int unsigned bad = 0;

    div8_seq #(.WIDTH(W)) dut (
        .drv_clk     (drv_clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 drv_clk = ~drv_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding command, result = plain / and %.
    int unsigned  cyc = 0;
    int unsigned  done_at = 0;
    bit           pending = 1'b0;
    logic [W-1:0] pq = '0, pr = '0;
    logic         pdz = 1'b0;
    logic         exp_busy = 1'b0, exp_done = 1'b0, exp_dz = 1'b0;
    logic [W-1:0] exp_q = '0, exp_r = '0;

    always @(posedge drv_clk or posedge reset) begin
        if (reset) begin
            pending  = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_dz   = 1'b0;
            exp_q    = '0;
            exp_r    = '0;
        end else begin
            cyc++;
            if (pending && cyc > done_at) pending = 1'b0;
            if (!pending && start) begin
                pending = 1'b1;
                exp_dz  = 1'b0;
                if (divisor == 0) begin
                    done_at = cyc + 1;
                    pq = 8'hFF; pr = dividend; pdz = 1'b1;
                end else begin
                    done_at = cyc + W + 1;
                    pq = dividend / divisor; pr = dividend % divisor; pdz = 1'b0;
                end
            end
            exp_done = pending && (cyc == done_at);
            exp_busy = pending;
            if (exp_done) begin
                exp_q  = pq;
                exp_r  = pr;
                exp_dz = pdz;
            end
        end
    end

    initial begin
        forever begin
            @(posedge drv_clk);
            #1;
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
            chk("div_by_zero", div_by_zero, exp_dz);
        end
    end

    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv);
        @(negedge drv_clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(negedge drv_clk);
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    endtask

    task automatic run(input logic [W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input int unsigned lat);
        int unsigned n;
        issue(dd, dv);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge drv_clk);
            n++;
        end
        chk("latency", n, lat);
        chk("lit_quotient", quotient, eq);
        chk("lit_remainder", remainder, er);
        chk("lit_dz", div_by_zero, edz);
    endtask

    initial begin
        int unsigned dones;
        #1 reset = 1'b1;
        repeat (3) @(negedge drv_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        reset = 1'b0;

        run(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, W + 1);
        run(8'd255, 8'd128, 8'd1,   8'd127, 1'b0, W + 1);
        run(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, W + 1);
        run(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, W + 1);
        run(8'd0,   8'd3,   8'd0,   8'd0,   1'b0, W + 1);
        run(8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 1);
        run(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, W + 1);

        // Start pulsed mid-RUN with other operands must be ignored.
        issue(8'd100, 8'd7);
        @(negedge drv_clk);
        start = 1'b1; dividend = 8'd33; divisor = 8'd4;
        @(negedge drv_clk);
        start = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge drv_clk);
            if (done === 1'b1) begin
                dones++;
                chk("midrun_quotient", quotient, 14);
                chk("midrun_remainder", remainder, 2);
            end
        end
        chk("midrun_done_count", dones, 1);

        // Reset during iteration 4 aborts without a done pulse.
        issue(8'd100, 8'd7);
        repeat (3) @(negedge drv_clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dz", div_by_zero, 0);
        @(negedge drv_clk);
        reset = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge drv_clk);
            if (done === 1'b1) dones++;
        end
        chk("abort_done_count", dones, 0);
        run(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, W + 1);

        // Randomized traffic; start may be held across done for back-to-back.
        for (int i = 0; i < 3000; i++) begin
            @(negedge drv_clk);
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            case ($urandom_range(0, 7))
                0:       divisor = '0;
                1:       divisor = W'($urandom_range(1, 3));
                2:       divisor = W'($urandom_range(128, 255));
                default: divisor = W'($urandom_range(1, 255));
            endcase
            reset = ($urandom_range(0, 399) == 0);
        end
        @(negedge drv_clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (12) @(negedge drv_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
